// File: rtl/stack_pkg.sv
// stack_pkg: shared types and helpers for the stack sequencer.
//   stack_op_t    - command encoding presented on cmd_op
//   stack_state_t - sequencer states
//   SP_DEC/SP_INC - values driven on lsu_sp_d
//   bounds_ok()   - checks that a push has room or a pop has data, given the current SP
package stack_pkg;

  typedef enum logic [1:0] {
    PUSH8  = 2'b00,
    POP8   = 2'b01,
    PUSH16 = 2'b10,
    POP16  = 2'b11
  } stack_op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    W    = 3'd1,
    INC  = 3'd2,
    RD   = 3'd3,
    CAP  = 3'd4,
    RESP = 3'd5
  } stack_state_t;

  localparam logic SP_DEC = 1'b0;
  localparam logic SP_INC = 1'b1;

  // Stack grows down and SP points at the next free byte.
  // Push needs (spq - lo + 1) >= n, pop needs (hi - spq) >= n.
  // 17-bit sums keep both tests free of wrap-around.
  function automatic logic bounds_ok(input stack_op_t op, input logic [15:0] spq,
                                     input logic [15:0] lo, input logic [15:0] hi);
    logic [16:0] n;
    n = op[1] ? 17'd2 : 17'd1;
    if (!op[0]) begin
      return ({1'b0, spq} + 17'd1) >= ({1'b0, lo} + n);
    end
    return {1'b0, hi} >= ({1'b0, spq} + n);
  endfunction

endpackage

// File: rtl/stack_seq.sv
// stack_seq: turns 8/16-bit push/pop commands into cycle-exact stack-pointer steps and
// SP-addressed RAM reads/writes on the LSU stack port, with bounds checking.
// Ports:
//   i_clk, i_rst (synchronous, active-low)
//   i_cmd_valid / o_cmd_ready / i_cmd_op / i_cmd_data : command request (accepted in IDLE)
//   o_rsp_valid / o_rsp_data / o_rsp_err               : one-cycle completion pulse
//   o_lsu_d, o_lsu_a, o_lsu_re, o_lsu_we              : RAM write byte, address, strobes
//   o_lsu_sp_d, o_lsu_sp_we, o_lsu_sp_en              : SP step direction / update / addressing
//   i_lsu_q, i_lsu_spq                                 : RAM read data, current SP
// All outputs are registered and decoded from the next state.
module stack_seq
  import stack_pkg::*;
#(
  parameter logic [15:0] SP_LO = 16'h0100,
  parameter logic [15:0] SP_HI = 16'h01FF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_op,
  input  logic [15:0] i_cmd_data,
  output logic        o_rsp_valid,
  output logic [15:0] o_rsp_data,
  output logic        o_rsp_err,
  output logic [7:0]  o_lsu_d,
  output logic [15:0] o_lsu_a,
  output logic        o_lsu_re,
  output logic        o_lsu_we,
  output logic        o_lsu_sp_d,
  output logic        o_lsu_sp_we,
  output logic        o_lsu_sp_en,
  input  logic [7:0]  i_lsu_q,
  input  logic [15:0] i_lsu_spq
);

  stack_state_t r_state, w_state_d;
  stack_op_t    r_op, w_op_d;
  logic         r_cnt, w_cnt_d;     // selects the second byte of a 16-bit op
  logic [15:0]  r_data, w_data_d;   // push value, or pop bytes as they are captured
  logic         r_err, w_err_d;
  logic         w_accept;

  logic         r_cmd_ready, w_cmd_ready_d;
  logic         r_rsp_valid, w_rsp_valid_d;
  logic [15:0]  r_rsp_data, w_rsp_data_d;
  logic         r_rsp_err, w_rsp_err_d;
  logic [7:0]   r_lsu_d, w_lsu_d_d;
  logic         r_lsu_re, w_lsu_re_d;
  logic         r_lsu_we, w_lsu_we_d;
  logic         r_lsu_sp_d, w_lsu_sp_d_d;
  logic         r_lsu_sp_we, w_lsu_sp_we_d;
  logic         r_lsu_sp_en, w_lsu_sp_en_d;

  assign w_accept = i_cmd_valid & r_cmd_ready;

  // State register (plus registered outputs)
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= IDLE;
      r_op        <= PUSH8;
      r_cnt       <= 1'b0;
      r_data      <= 16'h0000;
      r_err       <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 16'h0000;
      r_rsp_err   <= 1'b0;
      r_lsu_d     <= 8'h00;
      r_lsu_re    <= 1'b0;
      r_lsu_we    <= 1'b0;
      r_lsu_sp_d  <= 1'b0;
      r_lsu_sp_we <= 1'b0;
      r_lsu_sp_en <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_op        <= w_op_d;
      r_cnt       <= w_cnt_d;
      r_data      <= w_data_d;
      r_err       <= w_err_d;
      r_cmd_ready <= w_cmd_ready_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_rsp_data  <= w_rsp_data_d;
      r_rsp_err   <= w_rsp_err_d;
      r_lsu_d     <= w_lsu_d_d;
      r_lsu_re    <= w_lsu_re_d;
      r_lsu_we    <= w_lsu_we_d;
      r_lsu_sp_d  <= w_lsu_sp_d_d;
      r_lsu_sp_we <= w_lsu_sp_we_d;
      r_lsu_sp_en <= w_lsu_sp_en_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    w_op_d    = r_op;
    w_cnt_d   = r_cnt;
    w_data_d  = r_data;
    w_err_d   = r_err;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_op_d   = stack_op_t'(i_cmd_op);
          w_cnt_d  = 1'b0;
          w_err_d  = 1'b0;
          w_data_d = i_cmd_op[0] ? 16'h0000 : i_cmd_data;
          if (!bounds_ok(stack_op_t'(i_cmd_op), i_lsu_spq, SP_LO, SP_HI)) begin
            w_err_d   = 1'b1;
            w_data_d  = 16'h0000;
            w_state_d = RESP;
          end else if (i_cmd_op[0]) begin
            w_state_d = INC;
          end else begin
            w_state_d = W;
          end
        end
      end
      W: begin
        if (r_op == PUSH16 && !r_cnt) begin
          w_cnt_d = 1'b1;
        end else begin
          w_state_d = RESP;
        end
      end
      INC: begin
        // Second INC of a POP16 doubles as the capture of the low byte
        if (r_cnt) w_data_d[7:0] = i_lsu_q;
        w_state_d = RD;
      end
      RD: begin
        if (r_op == POP16 && !r_cnt) begin
          w_cnt_d   = 1'b1;
          w_state_d = INC;
        end else begin
          w_state_d = CAP;
        end
      end
      CAP: begin
        if (r_cnt) w_data_d[15:8] = i_lsu_q;
        else       w_data_d[7:0]  = i_lsu_q;
        w_state_d = RESP;
      end
      RESP:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  // Output decode of the next state; registered above
  always_comb begin
    w_cmd_ready_d = (w_state_d == IDLE);
    w_rsp_valid_d = 1'b0;
    w_rsp_data_d  = 16'h0000;
    w_rsp_err_d   = 1'b0;
    w_lsu_d_d     = r_lsu_d;
    w_lsu_re_d    = 1'b0;
    w_lsu_we_d    = 1'b0;
    w_lsu_sp_d_d  = SP_DEC;
    w_lsu_sp_we_d = 1'b0;
    w_lsu_sp_en_d = 1'b0;
    case (w_state_d)
      W: begin
        w_lsu_sp_en_d = 1'b1;
        w_lsu_we_d    = 1'b1;
        w_lsu_sp_we_d = 1'b1;
        w_lsu_sp_d_d  = SP_DEC;
        // PUSH16 writes the high byte first
        w_lsu_d_d     = (w_op_d == PUSH16 && !w_cnt_d) ? w_data_d[15:8] : w_data_d[7:0];
      end
      INC: begin
        w_lsu_sp_en_d = 1'b1;
        w_lsu_sp_we_d = 1'b1;
        w_lsu_sp_d_d  = SP_INC;
      end
      RD: begin
        w_lsu_sp_en_d = 1'b1;
        w_lsu_re_d    = 1'b1;
      end
      RESP: begin
        w_rsp_valid_d = 1'b1;
        w_rsp_err_d   = w_err_d;
        w_rsp_data_d  = (w_op_d[0] && !w_err_d) ? w_data_d : 16'h0000;
      end
      default: begin
      end
    endcase
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;
  assign o_lsu_d     = r_lsu_d;
  assign o_lsu_a     = 16'h0000;
  assign o_lsu_re    = r_lsu_re;
  assign o_lsu_we    = r_lsu_we;
  assign o_lsu_sp_d  = r_lsu_sp_d;
  assign o_lsu_sp_we = r_lsu_sp_we;
  assign o_lsu_sp_en = r_lsu_sp_en;

endmodule

// File: tb/tb_stack_seq.sv
// tb_stack_seq: self-checking bench for stack_seq. An LSU/RAM model sits on the stack port;
// expected responses, latencies, strobe counts and SP come from a byte-array stack model.
module tb_stack_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [7:0]  lsu_d;
  logic [15:0] lsu_a;
  logic        lsu_re, lsu_we, lsu_sp_d, lsu_sp_we, lsu_sp_en;
  logic [7:0]  lsu_q;
  logic [15:0] lsu_spq;

  logic [7:0]  ram [0:65535];
  logic        ram_clr, sp_load;
  logic [15:0] sp_load_val;

  logic [7:0]  exp_mem [0:65535];
  logic [15:0] sp_exp;
  int          n_checks = 0;
  int          n_errors = 0;

  logic [1:0]  s_op [0:7] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b11, 2'b01, 2'b11};

  always #5 clk = ~clk;

  stack_seq dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready),
    .i_cmd_op   (cmd_op),
    .i_cmd_data (cmd_data),
    .o_rsp_valid(rsp_valid),
    .o_rsp_data (rsp_data),
    .o_rsp_err  (rsp_err),
    .o_lsu_d    (lsu_d),
    .o_lsu_a    (lsu_a),
    .o_lsu_re   (lsu_re),
    .o_lsu_we   (lsu_we),
    .o_lsu_sp_d (lsu_sp_d),
    .o_lsu_sp_we(lsu_sp_we),
    .o_lsu_sp_en(lsu_sp_en),
    .i_lsu_q    (lsu_q),
    .i_lsu_spq  (lsu_spq)
  );

  // LSU: write at current SP and step SP on the same edge; read data one cycle after re
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
    end else if (lsu_sp_en && lsu_we) begin
      ram[lsu_spq] <= lsu_d;
    end
    if (sp_load) lsu_spq <= sp_load_val;
    else if (lsu_sp_we) lsu_spq <= lsu_sp_d ? lsu_spq + 16'd1 : lsu_spq - 16'd1;
    if (lsu_sp_en && lsu_re) lsu_q <= ram[lsu_spq];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Stack reference: n bytes of room/data decided from SP, bytes kept in exp_mem
  task automatic predict(input logic [1:0] op, input logic [15:0] dat, output logic e_err,
                         output logic [15:0] e_data, output int e_lat, output int e_we,
                         output int e_re);
    int n, free_b, used_b;
    n      = op[1] ? 2 : 1;
    free_b = int'(sp_exp) - 32'h100 + 1;
    used_b = 32'h1FF - int'(sp_exp);
    e_data = 16'h0000;
    e_we   = 0;
    e_re   = 0;
    e_lat  = 1;
    if (!op[0]) begin
      e_err = (free_b < n);
      if (!e_err) begin
        if (n == 2) begin
          exp_mem[sp_exp] = dat[15:8];
          sp_exp          = sp_exp - 16'd1;
        end
        exp_mem[sp_exp] = dat[7:0];
        sp_exp          = sp_exp - 16'd1;
        e_we            = n;
        e_lat           = n + 1;
      end
    end else begin
      e_err = (used_b < n);
      if (!e_err) begin
        e_data[7:0] = exp_mem[sp_exp + 16'd1];
        if (n == 2) e_data[15:8] = exp_mem[sp_exp + 16'd2];
        sp_exp = sp_exp + 16'(n);
        e_re   = n;
        e_lat  = 2 * n + 2;
      end
    end
  endtask

  task automatic set_sp(input logic [15:0] v);
    @(negedge clk);
    sp_load     = 1'b1;
    sp_load_val = v;
    @(negedge clk);
    sp_load = 1'b0;
    sp_exp  = v;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [15:0] dat, output logic [15:0] got);
    logic        e_err;
    logic [15:0] e_data;
    int          e_lat, e_we, e_re, lat, nwe, nre, waited;
    logic        seen;
    waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("ready_wait", {31'b0, cmd_ready}, 32'd1);
    predict(op, dat, e_err, e_data, e_lat, e_we, e_re);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = dat;
    @(posedge clk);
    lat  = 0;
    nwe  = 0;
    nre  = 0;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      lat++;
      nwe += int'(lsu_we);
      nre += int'(lsu_re);
      if (rsp_valid) seen = 1'b1;
    end
    got = rsp_data;
    check("rsp_seen", {31'b0, seen}, 32'd1);
    check("latency", lat, e_lat);
    check("rsp_err", {31'b0, rsp_err}, {31'b0, e_err});
    check("rsp_data", {16'b0, rsp_data}, {16'b0, e_data});
    check("we_count", nwe, e_we);
    check("re_count", nre, e_re);
    check("sp_after", {16'b0, lsu_spq}, {16'b0, sp_exp});
    if (!op[0] && !e_err)
      check("ram_byte", {24'b0, ram[sp_exp + 16'd1]}, {24'b0, exp_mem[sp_exp + 16'd1]});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] got;
    logic        e_err;
    logic [15:0] e_data;
    int          e_lat, e_we, e_re, idx, nrsp, cyc, saw_rsp;
    logic [16:0] exp_q[$];
    logic [16:0] e_pair;
    logic [15:0] s_dat [0:7];
    logic [15:0] pick [0:6];

    for (int i = 0; i < 65536; i++) exp_mem[i] = 8'h00;
    rst         = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = 2'b00;
    cmd_data    = 16'h0000;
    ram_clr     = 1'b1;
    sp_load     = 1'b1;
    sp_load_val = 16'h01FF;
    sp_exp      = 16'h01FF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'b0, cmd_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_strobes", {27'b0, lsu_re, lsu_we, lsu_sp_d, lsu_sp_we, lsu_sp_en}, 32'd0);
    check("rst_lsu_d", {24'b0, lsu_d}, 32'd0);
    ram_clr = 1'b0;
    sp_load = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'b0, cmd_ready}, 32'd1);
    check("post_rst_rsp", {15'b0, rsp_valid, rsp_data}, 32'd0);
    check("lsu_a_tied", {16'b0, lsu_a}, 32'd0);

    // Directed scenarios
    do_cmd(2'b00, 16'h00A5, got);
    check("push8_ram", {24'b0, ram[16'h01FF]}, 32'h0000_00A5);
    set_sp(16'h01FF);
    do_cmd(2'b10, 16'h1234, got);
    check("push16_hi", {24'b0, ram[16'h01FF]}, 32'h0000_0012);
    check("push16_lo", {24'b0, ram[16'h01FE]}, 32'h0000_0034);
    do_cmd(2'b11, 16'h0000, got);
    check("pop16_val", {16'b0, got}, 32'h0000_1234);
    do_cmd(2'b01, 16'h0000, got);
    set_sp(16'h0100);
    do_cmd(2'b10, 16'hBEEF, got);
    do_cmd(2'b00, 16'h0077, got);
    check("push8_edge", {16'b0, lsu_spq}, 32'h0000_00FF);
    check("push8_edge_ram", {24'b0, ram[16'h0100]}, 32'h0000_0077);
    do_cmd(2'b00, 16'h0011, got);

    // Continuous cmd_valid; garbage ops while busy must be ignored
    set_sp(16'h01FF);
    for (int i = 0; i < 8; i++) s_dat[i] = 16'($urandom);
    idx     = 0;
    nrsp    = 0;
    cyc     = 0;
    while ((idx < 8 || nrsp < 8) && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) begin
        check("stream_q_nonempty", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() > 0) begin
          e_pair = exp_q.pop_front();
          check("stream_rsp", {15'b0, rsp_err, rsp_data}, {15'b0, e_pair});
        end
        nrsp++;
      end
      if (idx < 8) begin
        cmd_valid = 1'b1;
        if (cmd_ready) begin
          cmd_op   = s_op[idx];
          cmd_data = s_dat[idx];
          predict(s_op[idx], s_dat[idx], e_err, e_data, e_lat, e_we, e_re);
          exp_q.push_back({e_err, e_data});
          idx++;
        end else begin
          cmd_op   = 2'($urandom);
          cmd_data = 16'($urandom);
        end
      end else begin
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    check("stream_count", nrsp, 8);
    check("stream_sp", {16'b0, lsu_spq}, {16'b0, sp_exp});

    // Reset during the first RD of a POP16
    set_sp(16'h01FF);
    do_cmd(2'b10, 16'hABCD, got);
    @(negedge clk);
    check("mid_ready", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_inc", {31'b0, lsu_sp_we}, 32'd1);
    @(negedge clk);
    check("mid_rd", {31'b0, lsu_re}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_strobes", {27'b0, lsu_re, lsu_we, lsu_sp_d, lsu_sp_we, lsu_sp_en}, 32'd0);
    check("mid_rst_ready", {31'b0, cmd_ready}, 32'd0);
    saw_rsp = int'(rsp_valid);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_release_ready", {31'b0, cmd_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      saw_rsp += int'(rsp_valid);
      @(negedge clk);
    end
    check("mid_no_rsp", saw_rsp, 0);
    check("mid_sp", {16'b0, lsu_spq}, 32'h0000_01FE);

    // Randomized traffic, SP occasionally moved near the bounds
    pick[0] = 16'h0100; pick[1] = 16'h0101; pick[2] = 16'h0102; pick[3] = 16'h01FF;
    pick[4] = 16'h01FE; pick[5] = 16'h01FD; pick[6] = 16'h0180;
    set_sp(16'h01FF);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) set_sp(pick[$urandom_range(0, 6)]);
      do_cmd(2'($urandom), 16'($urandom), got);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stack_seq.md
# stack_seq

Stack sequencer for the 8-bit core: initiator on the load/store unit's stack-port interface. Accepts push/pop commands of 8- or 16-bit values from the execute stage and turns each into a cycle-exact sequence of stack-pointer updates and stack-addressed RAM reads or writes. It also performs stack-bounds checking. It sits between the execute stage and the LSU and is the only block that asserts the LSU's stack-pointer controls.

## Interface
- SP_LO, 16'h0100, lowest usable stack byte address
- SP_HI, 16'h01FF, highest usable stack byte address; `lsu_spq == SP_HI` means empty
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; a command is accepted on `cmd_valid & cmd_ready`
- cmd_op  in  2  00 PUSH8, 01 POP8, 10 PUSH16, 11 POP16
- cmd_data  in  16  push value; PUSH8 uses [7:0]
- rsp_valid  out  1  one-cycle completion pulse, no back-pressure
- rsp_data  out  16  pop result, zero-extended for POP8; 0 for pushes and errors
- rsp_err  out  1  bounds violation, valid with `rsp_valid`
- lsu_d  out  8  write byte
- lsu_a  out  16  tied 0; the address comes from SP while `lsu_sp_en` is high
- lsu_re, lsu_we  out  1  RAM read / write strobes
- lsu_sp_d  out  1  SP step direction: 0 decrement, 1 increment
- lsu_sp_we, lsu_sp_en  out  1  SP update strobe / SP addressing enable
- lsu_q  in  8  RAM read data, valid the cycle after `lsu_re`
- lsu_spq  in  16  current SP

## Operation
- Stack model
  - The stack grows downward.
  - SP points to the next free byte.
  - Free bytes = `lsu_spq - SP_LO + 1`.
  - Used bytes = `SP_HI - lsu_spq`.
- Bounds check, done in IDLE on acceptance using `lsu_spq`
  - A push needs free ≥ n; a pop needs used ≥ n, where n is 1 or 2.
  - On failure: no LSU strobes, go to RESP with `rsp_err=1` and `rsp_data=0`.
- Write byte (W state)
  - `lsu_sp_en=1`, `lsu_we=1`, `lsu_d=byte`, `lsu_sp_we=1`, `lsu_sp_d=0`.
  - The RAM write at the old SP and the SP decrement occur on the same edge.
- Read byte, three states
  - INC: `lsu_sp_en=1`, `lsu_sp_we=1`, `lsu_sp_d=1`.
  - RD: `lsu_sp_en=1`, `lsu_re=1`.
  - CAP: register `lsu_q` into the byte slot.
  - For POP16, CAP of the low byte overlaps INC of the high byte, which is legal because RD has already completed.
- Byte order
  - PUSH16 writes the high byte, then the low byte.
  - POP16 reads the low byte, then the high byte, so memory is little-endian at SP+1.
- States: IDLE, W, INC, RD, CAP, RESP. A 1-bit byte counter selects the second byte.
- All LSU outputs and `rsp_*` are registered (Moore).
  - Every strobe is 0 in IDLE and RESP.
  - `lsu_d` holds its last value.
- RESP lasts one cycle and always returns to IDLE.
- Commands presented outside IDLE are ignored and not latched.

## Timing
Accept edge = cycle T.

| Command | Cycle-by-cycle sequence | rsp_valid |
|---|---|---|
| PUSH8 | W at T+1 | T+2 |
| PUSH16 | W(hi) at T+1, W(lo) at T+2 | T+3 |
| POP8 | INC T+1, RD T+2, CAP T+3 | T+4 |
| POP16 | INC T+1, RD T+2, CAP+INC T+3, RD T+4, CAP T+5 | T+6 |
| Any bounds error | none | T+1 |

- Throughput: `cmd_ready` rises the cycle after RESP, so the minimum command spacing is latency + 1.
- Reset
  - Outputs are 0 from the first clock edge with `rst=0`; `cmd_ready` is 0 while `rst=0`.
  - After release: state IDLE, `cmd_ready=1`, `rsp_*=0`, `lsu_d=0`.
  - Reset mid-sequence abandons the sequence with no response. Any SP step already taken remains; SP re-initialisation belongs to the LSU's own reset.
- Boundaries
  - PUSH16 with exactly 1 free byte → error; nothing is written and SP is unchanged.
  - POP on empty (`lsu_spq == SP_HI`) → error.

## Structure
- Package `stack_pkg`:
  - `stack_op_t` enum (PUSH8/POP8/PUSH16/POP16)
  - `stack_state_t` enum (IDLE/W/INC/RD/CAP/RESP)
  - direction constants `SP_DEC=0`, `SP_INC=1`
- Single module, no sub-modules. The bounds check is a function in `stack_pkg`: `bounds_ok(op, spq, lo, hi)`.

## Test plan
- Reset, then PUSH8 `8'hA5` with SP `16'h01FF` → write `A5` @ `01FF` at T+1, SP becomes `01FE`, `rsp_valid` at T+2 with `rsp_err=0`.
- PUSH16 `16'h1234` from SP `01FF`, then POP16 → writes `12`@`01FF`, `34`@`01FE`; POP16 returns `rsp_data=16'h1234` at T+6 and SP is back at `01FF`.
- POP8 with SP `01FF` (empty) → no strobes, `rsp_valid` with `rsp_err=1` at T+1, SP unchanged.
- SP `16'h0100` (1 free byte): PUSH16 → error with no write; PUSH8 `8'h77` → succeeds and SP becomes `00FF`.
- Hold `cmd_valid` continuously with alternating ops → each accepted only when `cmd_ready=1`; no command is lost or duplicated.
- Assert `rst=0` during the RD of a POP16 → next cycle all strobes are 0, no `rsp_valid` ever, IDLE with `cmd_ready=1` after release.
